// File: rtl/jtcop_sndrom_arb.sv
// Shares one byte-wide ROM port between the sound CPU and the ADPCM reader.
// Each requester has a one-entry cache; misses are arbitrated round-robin.
module jtcop_sndrom_arb #(
  parameter logic [18:0] CPU_BASE = 19'h00000,
  parameter logic [18:0] PCM_BASE = 19'h20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic [16:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic        cpu_ok,
  input  logic        pcm_cs,
  input  logic [17:0] pcm_addr,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,
  output logic        mem_cs,
  output logic [18:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_ok,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a requester holds cs with a stable address; ok is high in the
  // same cycle the cached tag matches. Downstream, mem_cs/mem_addr stay put
  // until mem_ok is seen high, and mem_ok is meaningless while mem_cs is low.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    PCM_RD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_cpu_valid;
  logic [16:0] r_cpu_tag;
  logic [7:0]  r_cpu_data;
  logic        r_pcm_valid;
  logic [17:0] r_pcm_tag;
  logic [7:0]  r_pcm_data;
  logic        r_last_pcm;
  logic [17:0] r_xact_tag;
  logic [18:0] r_mem_addr;

  logic w_cpu_hit;
  logic w_pcm_hit;
  logic w_cpu_pend;
  logic w_pcm_pend;
  logic w_fill;

  assign w_cpu_hit  = r_cpu_valid & (cpu_addr == r_cpu_tag);
  assign w_pcm_hit  = r_pcm_valid & (pcm_addr == r_pcm_tag);
  assign w_cpu_pend = cpu_cs & ~w_cpu_hit;
  assign w_pcm_pend = pcm_cs & ~w_pcm_hit;

  assign cpu_ok      = ~rst & cpu_cs & w_cpu_hit;
  assign pcm_ok      = ~rst & pcm_cs & w_pcm_hit;
  assign cpu_data    = r_cpu_data;
  assign pcm_data    = r_pcm_data;
  assign mem_cs      = (r_state != IDLE);
  assign mem_addr    = r_mem_addr;
  assign o_dbg_state = r_state;

  // Only a granted transaction may consume mem_ok.
  assign w_fill = (r_state != IDLE) & mem_ok;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cpu_pend && w_pcm_pend) w_next = r_last_pcm ? CPU_RD : PCM_RD;
        else if (w_cpu_pend)          w_next = CPU_RD;
        else if (w_pcm_pend)          w_next = PCM_RD;
      end
      CPU_RD:  if (mem_ok) w_next = IDLE;
      PCM_RD:  if (mem_ok) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cpu_valid <= 1'b0;
      r_cpu_tag   <= '0;
      r_cpu_data  <= '0;
      r_pcm_valid <= 1'b0;
      r_pcm_tag   <= '0;
      r_pcm_data  <= '0;
      r_last_pcm  <= 1'b1;
      r_xact_tag  <= '0;
      r_mem_addr  <= CPU_BASE;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == CPU_RD) begin
        r_xact_tag <= {1'b0, cpu_addr};
        r_mem_addr <= CPU_BASE + {2'b00, cpu_addr};
      end
      if (r_state == IDLE && w_next == PCM_RD) begin
        r_xact_tag <= pcm_addr;
        r_mem_addr <= PCM_BASE + {1'b0, pcm_addr};
      end
      // The fill uses the latched tag, so a requester moving its address
      // mid-fetch still misses on the new one.
      if (w_fill && r_state == CPU_RD) begin
        r_cpu_valid <= 1'b1;
        r_cpu_tag   <= r_xact_tag[16:0];
        r_cpu_data  <= mem_data;
        r_last_pcm  <= 1'b0;
      end
      if (w_fill && r_state == PCM_RD) begin
        r_pcm_valid <= 1'b1;
        r_pcm_tag   <= r_xact_tag;
        r_pcm_data  <= mem_data;
        r_last_pcm  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtcop_sndrom_arb.sv
// Directed bench for jtcop_sndrom_arb with a fixed-latency ROM model.
module tb_jtcop_sndrom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic        pcm_cs;
  logic [17:0] pcm_addr;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic        mem_cs;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ok;
  logic [1:0]  dbg_state;

  // second instance: wrap-around of the PCM base, no memory behind it
  logic        w2_pcm_cs;
  logic [17:0] w2_pcm_addr;
  logic [7:0]  w2_cpu_data;
  logic        w2_cpu_ok;
  logic [7:0]  w2_pcm_data;
  logic        w2_pcm_ok;
  logic        w2_mem_cs;
  logic [18:0] w2_mem_addr;
  logic [1:0]  w2_dbg_state;

  logic        auto_en;
  logic        force_ok;
  int          cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  jtcop_sndrom_arb u_dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ok(mem_ok),
    .o_dbg_state(dbg_state)
  );

  jtcop_sndrom_arb #(.CPU_BASE(19'h00000), .PCM_BASE(19'h7FFF0)) u_wrap (
    .clk(clk), .rst(rst),
    .cpu_cs(1'b0), .cpu_addr(17'h0), .cpu_data(w2_cpu_data), .cpu_ok(w2_cpu_ok),
    .pcm_cs(w2_pcm_cs), .pcm_addr(w2_pcm_addr), .pcm_data(w2_pcm_data), .pcm_ok(w2_pcm_ok),
    .mem_cs(w2_mem_cs), .mem_addr(w2_mem_addr), .mem_data(8'h00), .mem_ok(1'b0),
    .o_dbg_state(w2_dbg_state)
  );

  function automatic logic [7:0] mem_byte(input logic [18:0] a);
    if (a == 19'h00100) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
  endfunction

  // ROM with 3-cycle latency: mem_ok in the third cycle mem_cs is high
  always @(posedge clk) begin
    if (!mem_cs) cnt <= 0;
    else         cnt <= cnt + 1;
  end
  assign mem_ok   = force_ok | (auto_en & mem_cs & (cnt >= 2));
  assign mem_data = mem_byte(mem_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    cpu_cs = 1'b0; pcm_cs = 1'b0; w2_pcm_cs = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic wait_fill(input string name);
    for (int i = 0; i < 20 && mem_cs; i++) tick;
    checks++;
    if (mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout: mem_cs=%b required 0 within 20 cycles", name, mem_cs);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL reset_mem_cs got %b exp 0", mem_cs); end
    checks++; if (mem_addr !== 19'h00000) begin errors++; $display("FAIL reset_mem_addr got %h exp 00000", mem_addr); end
    checks++; if (cpu_data !== 8'h00 || pcm_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h/%h exp 00/00", cpu_data, pcm_data); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_cold_miss;
    int first_ok;
    int cs_cycles;
    logic [18:0] seen_addr;
    first_ok = 0; cs_cycles = 0; seen_addr = '1;
    tick;
    cpu_addr = 17'h00100; cpu_cs = 1'b1;
    #1;
    // cycle 1 is the one in which cpu_cs rises
    for (int c = 1; c <= 8; c++) begin
      if (cpu_ok && first_ok == 0) first_ok = c;
      if (mem_cs) begin cs_cycles++; seen_addr = mem_addr; end
      tick;
    end
    checks++; if (seen_addr !== 19'h00100) begin errors++; $display("FAIL cold_mem_addr got %h exp 00100", seen_addr); end
    checks++; if (cs_cycles !== 3) begin errors++; $display("FAIL cold_cs_cycles got %0d exp 3", cs_cycles); end
    checks++; if (first_ok !== 5) begin errors++; $display("FAIL cold_ok_cycle got %0d exp 5", first_ok); end
    checks++; if (cpu_data !== 8'hA5) begin errors++; $display("FAIL cold_data got %h exp a5", cpu_data); end
  endtask

  task automatic test_hit;
    int cs_seen;
    cs_seen = 0;
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("FAIL hit_ok got %b exp 1", cpu_ok); end
    for (int i = 0; i < 3; i++) begin
      if (mem_cs) cs_seen++;
      tick;
    end
    checks++; if (cs_seen !== 0) begin errors++; $display("FAIL hit_mem_cs cycles got %0d exp 0", cs_seen); end
    cpu_addr = 17'h00101;
    #1;
    checks++; if (cpu_ok !== 1'b0) begin errors++; $display("FAIL hit_other_addr got %b exp 0", cpu_ok); end
    cpu_addr = 17'h00100;
    #1;
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("FAIL hit_restore got %b exp 1", cpu_ok); end
    tick;
    rst = 1'b1;
    #1;
    checks++; if (cpu_ok !== 1'b0) begin errors++; $display("FAIL hit_during_rst got %b exp 0", cpu_ok); end
    rst = 1'b0;
    #1;
    checks++; if (cpu_ok !== 1'b1) begin errors++; $display("FAIL hit_after_rst_drop got %b exp 1", cpu_ok); end
    tick;
    cpu_cs = 1'b0;
    #1;
    checks++; if (cpu_ok !== 1'b0) begin errors++; $display("FAIL hit_no_cs got %b exp 0", cpu_ok); end
  endtask

  task automatic test_pcm_offset;
    tick;
    pcm_addr = 18'h00010; pcm_cs = 1'b1;
    tick;
    checks++; if (mem_cs !== 1'b1 || mem_addr !== 19'h20010) begin errors++; $display("FAIL pcm_addr got cs=%b %h exp cs=1 20010", mem_cs, mem_addr); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL pcm_state got %0d exp 2", dbg_state); end
    wait_fill("pcm_fill");
    checks++; if (pcm_ok !== 1'b1 || pcm_data !== mem_byte(19'h20010)) begin errors++; $display("FAIL pcm_data got ok=%b %h exp ok=1 %h", pcm_ok, pcm_data, mem_byte(19'h20010)); end
    pcm_cs = 1'b0;
    w2_pcm_addr = 18'h00020; w2_pcm_cs = 1'b1;
    tick;
    checks++; if (w2_mem_cs !== 1'b1 || w2_mem_addr !== 19'h00010) begin errors++; $display("FAIL pcm_wrap got cs=%b %h exp cs=1 00010", w2_mem_cs, w2_mem_addr); end
    w2_pcm_cs = 1'b0;
  endtask

  task automatic test_tie;
    do_reset;
    tick;
    cpu_addr = 17'h00300; pcm_addr = 18'h00400;
    cpu_cs = 1'b1; pcm_cs = 1'b1;
    tick;
    checks++; if (dbg_state !== 2'd1 || mem_addr !== 19'h00300) begin errors++; $display("FAIL tie1_grant got st=%0d %h exp st=1 00300", dbg_state, mem_addr); end
    cpu_addr = 17'h00301;
    wait_fill("tie1_fill");
    checks++; if (dbg_state !== 2'd0 || cpu_ok !== 1'b0) begin errors++; $display("FAIL tie1_gap got st=%0d ok=%b exp st=0 ok=0", dbg_state, cpu_ok); end
    tick;
    checks++; if (dbg_state !== 2'd2 || mem_addr !== 19'h20400) begin errors++; $display("FAIL tie2_grant got st=%0d %h exp st=2 20400", dbg_state, mem_addr); end
    wait_fill("tie2_fill");
    checks++; if (pcm_ok !== 1'b1 || pcm_data !== mem_byte(19'h20400)) begin errors++; $display("FAIL tie2_data got ok=%b %h exp ok=1 %h", pcm_ok, pcm_data, mem_byte(19'h20400)); end
    tick;
    checks++; if (dbg_state !== 2'd1 || mem_addr !== 19'h00301) begin errors++; $display("FAIL tie3_grant got st=%0d %h exp st=1 00301", dbg_state, mem_addr); end
    wait_fill("tie3_fill");
    checks++; if (cpu_ok !== 1'b1 || cpu_data !== mem_byte(19'h00301)) begin errors++; $display("FAIL tie3_data got ok=%b %h exp ok=1 %h", cpu_ok, cpu_data, mem_byte(19'h00301)); end
    cpu_cs = 1'b0; pcm_cs = 1'b0;
  endtask

  task automatic test_addr_change;
    do_reset;
    tick;
    cpu_addr = 17'h00200; cpu_cs = 1'b1;
    tick;
    checks++; if (dbg_state !== 2'd1 || mem_addr !== 19'h00200) begin errors++; $display("FAIL chg_grant got st=%0d %h exp st=1 00200", dbg_state, mem_addr); end
    cpu_addr = 17'h00201;
    wait_fill("chg_fill");
    checks++; if (cpu_ok !== 1'b0) begin errors++; $display("FAIL chg_new_ok got %b exp 0", cpu_ok); end
    cpu_addr = 17'h00200;
    #1;
    checks++; if (cpu_ok !== 1'b1 || cpu_data !== mem_byte(19'h00200)) begin errors++; $display("FAIL chg_stale_tag got ok=%b %h exp ok=1 %h", cpu_ok, cpu_data, mem_byte(19'h00200)); end
    cpu_addr = 17'h00201;
    tick;
    checks++; if (dbg_state !== 2'd1 || mem_addr !== 19'h00201) begin errors++; $display("FAIL chg_second got st=%0d %h exp st=1 00201", dbg_state, mem_addr); end
    wait_fill("chg_fill2");
    checks++; if (cpu_ok !== 1'b1 || cpu_data !== mem_byte(19'h00201)) begin errors++; $display("FAIL chg_data got ok=%b %h exp ok=1 %h", cpu_ok, cpu_data, mem_byte(19'h00201)); end
    cpu_cs = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    tick;
    pcm_addr = 18'h00500; pcm_cs = 1'b1; auto_en = 1'b0;
    tick;
    checks++; if (mem_cs !== 1'b1 || dbg_state !== 2'd2) begin errors++; $display("FAIL rmid_grant got cs=%b st=%0d exp cs=1 st=2", mem_cs, dbg_state); end
    tick; tick;
    rst = 1'b1; force_ok = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    checks++; if (mem_cs !== 1'b0 || pcm_ok !== 1'b0) begin errors++; $display("FAIL rmid_abort got cs=%b ok=%b exp cs=0 ok=0", mem_cs, pcm_ok); end
    tick;
    force_ok = 1'b0;
    checks++; if (pcm_ok !== 1'b0 || mem_cs !== 1'b1) begin errors++; $display("FAIL rmid_refetch got ok=%b cs=%b exp ok=0 cs=1", pcm_ok, mem_cs); end
    tick; tick;
    checks++; if (pcm_ok !== 1'b0) begin errors++; $display("FAIL rmid_wait got ok=%b exp 0", pcm_ok); end
    auto_en = 1'b1;
    wait_fill("rmid_fill");
    checks++; if (pcm_ok !== 1'b1 || pcm_data !== mem_byte(19'h20500)) begin errors++; $display("FAIL rmid_data got ok=%b %h exp ok=1 %h", pcm_ok, pcm_data, mem_byte(19'h20500)); end
    pcm_cs = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_cs = 1'b0; cpu_addr = '0;
    pcm_cs = 1'b0; pcm_addr = '0;
    w2_pcm_cs = 1'b0; w2_pcm_addr = '0;
    auto_en = 1'b1; force_ok = 1'b0;
    test_reset;
    test_cold_miss;
    test_hit;
    test_pcm_offset;
    test_tie;
    test_addr_change;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtcop_sndrom_arb.md
JTCOP_SNDROM_ARB -- requirements
Module: jtcop_sndrom_arb

Interface
REQ-001 The block SHALL have parameter CPU_BASE, default 19'h00000, giving the byte offset of the sound CPU region in the shared ROM.
REQ-002 The block SHALL have parameter PCM_BASE, default 19'h20000, giving the byte offset of the ADPCM region in the shared ROM.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port cpu_cs, input, 1 bit: sound CPU ROM request.
REQ-006 The block SHALL have port cpu_addr, input, 17 bits: CPU byte address, {snd_bank, A[15:0]}.
REQ-007 The block SHALL have port cpu_data, output, 8 bits: CPU read data.
REQ-008 The block SHALL have port cpu_ok, output, 1 bit: cpu_data is valid for cpu_addr.
REQ-009 The block SHALL have port pcm_cs, input, 1 bit: ADPCM ROM request.
REQ-010 The block SHALL have port pcm_addr, input, 18 bits: ADPCM byte address.
REQ-011 The block SHALL have port pcm_data, output, 8 bits: ADPCM read data.
REQ-012 The block SHALL have port pcm_ok, output, 1 bit: pcm_data is valid for pcm_addr.
REQ-013 The block SHALL have port mem_cs, output, 1 bit: shared ROM request.
REQ-014 The block SHALL have port mem_addr, output, 19 bits: shared ROM byte address.
REQ-015 The block SHALL have port mem_data, input, 8 bits: shared ROM data.
REQ-016 The block SHALL have port mem_ok, input, 1 bit: mem_data is valid for the current mem_addr.

Function
REQ-017 Each requester SHALL own a one-entry cache: valid bit, tag (its address width), data byte.
REQ-018 Hit detection SHALL be combinational from registered state:
- cpu_ok = cpu_cs & cpu_valid & (cpu_addr == cpu_tag); pcm_ok is formed likewise.
- cpu_data and pcm_data SHALL always drive the cached byte.
REQ-019 A requester SHALL be "pending" when its cs is high and its ok is low (a miss).
REQ-020 The FSM SHALL have three states: IDLE, CPU_RD, PCM_RD.
REQ-021 In IDLE, with exactly one requester pending, the FSM SHALL enter that requester's *_RD state at the next edge.
REQ-022 In IDLE, with both requesters pending, the FSM SHALL grant the requester not granted last (round-robin).
REQ-023 On entering *_RD, the block SHALL latch the requester's address into a transaction tag.
- mem_addr SHALL equal (BASE + zero-extended address) mod 2^19.
- mem_cs SHALL be 1, with mem_addr held stable until mem_ok is sampled high.
REQ-024 In *_RD, mem_ok SHALL be sampled each cycle. When it is high, at that edge the block SHALL:
- write the cache with data = mem_data, tag = transaction tag, valid = 1;
- return to IDLE with mem_cs = 0;
- update the last-grant record.
REQ-025 mem_ok SHALL be ignored whenever mem_cs is 0.
REQ-026 Between consecutive transactions, IDLE SHALL last at least one cycle, so mem_cs is low for at least one cycle.
REQ-027 A requester that changes address or drops cs mid-transaction SHALL NOT abort the transaction.
- The fill completes into the stale tag, and ok stays low for the new address.
- The new address is serviced by a later grant.
REQ-028 Miss latency (cs rising in IDLE to ok high) SHALL be mem latency + 2 cycles. Hit latency SHALL be 0 cycles (same cycle).
REQ-029 The block SHALL NOT starve either requester: a pending requester is granted after at most one transaction of the other.
REQ-030 Address arithmetic SHALL wrap modulo 2^19, with no overflow flag.

Reset
REQ-031 On rst at a clock edge, the block SHALL set:
- state = IDLE and mem_cs = 0;
- mem_addr = CPU_BASE;
- both cache valid bits = 0, and tags and data = 0;
- last-grant = PCM, so the CPU wins the first tie.
REQ-032 Reset during CPU_RD or PCM_RD SHALL abandon the transaction, with no cache write. Any mem_ok arriving after reset SHALL be ignored.
REQ-033 While rst is high, cpu_ok and pcm_ok SHALL be 0.

Verification
REQ-034 Cold CPU miss: after reset, cpu_cs = 1 and cpu_addr = 17'h00100; memory returns 8'hA5 with 3-cycle latency -> the following SHALL hold:
- mem_addr = 19'h00100;
- mem_cs is high for 3 cycles;
- cpu_ok rises 5 cycles after cpu_cs, with cpu_data = 8'hA5.
REQ-035 Hit: repeat cpu_addr = 17'h00100 after REQ-034 -> cpu_ok = 1 in the same cycle and mem_cs stays 0.
REQ-036 PCM offset and wrap-around:
- pcm_addr = 18'h00010 -> mem_addr = 19'h20010;
- PCM_BASE = 19'h7FFF0 with pcm_addr = 18'h00020 -> mem_addr = 19'h00010.
REQ-037 Tie: cpu_cs and pcm_cs both miss in the same IDLE cycle after reset -> the following SHALL hold:
- the CPU is served first;
- mem_cs is low for at least one cycle;
- the PCM is served next;
- on the next tie, the PCM is served first.
REQ-038 Address change mid-fetch: cpu_addr changes from 17'h00200 to 17'h00201 during CPU_RD -> the following SHALL hold:
- cpu_ok stays 0;
- the fill completes, tagged 17'h00200;
- a second transaction with mem_addr = 19'h00201 follows.
REQ-039 Reset mid-fetch: assert rst during PCM_RD, then pulse mem_ok -> mem_cs = 0, and pcm_ok stays 0 for the same pcm_addr until a fresh fetch completes.
